// File: rtl/frame_write_sequencer.sv
// frame_write_sequencer: takes a header (start frame, column, count) and then
// writes each data word into a column's frame chain with SETUP/STROBE/HOLD timing.
module frame_write_sequencer #(
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int NumColumns      = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       s_valid,
    input  logic [FrameBitsPerRow-1:0] s_data,
    output logic                       s_ready,
    output logic [FrameBitsPerRow-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0] FrameStrobe,
    output logic [7:0]                 ColSel,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_DATA,
        SETUP,
        STROBE,
        HOLD
    } state_t;

    localparam logic [5:0] FrameSat = 6'h3F;
    localparam logic [MaxFramesPerCol-1:0] OneHot = MaxFramesPerCol'(1);

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_frame;
    logic [7:0]  r_remaining;
    logic        w_hdr_acc;
    logic        w_data_acc;
    logic        w_err_set;
    logic        w_done_set;
    logic        w_legal;

    // A write is legal only for an in-range frame index and column.
    assign w_legal = ({26'd0, r_frame} < 32'(MaxFramesPerCol))
                  && ({24'd0, ColSel} < 32'(NumColumns));

    // State register.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, handshake and event decode.
    always_comb begin
        w_next     = r_state;
        s_ready    = 1'b0;
        busy       = 1'b1;
        w_hdr_acc  = 1'b0;
        w_data_acc = 1'b0;
        w_err_set  = 1'b0;
        w_done_set = 1'b0;
        unique case (r_state)
            IDLE: begin
                s_ready = 1'b1;
                busy    = 1'b0;
                if (s_valid) begin
                    w_hdr_acc = 1'b1;
                    if (s_data[7:0] != 8'd0) begin
                        w_next = WAIT_DATA;
                    end else begin
                        w_done_set = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_data_acc = 1'b1;
                    w_next     = SETUP;
                end
            end
            SETUP: begin
                w_next    = STROBE;
                w_err_set = !w_legal;
            end
            STROBE: begin
                w_next = HOLD;
            end
            HOLD: begin
                if (r_remaining != 8'd0) begin
                    w_next = WAIT_DATA;
                end else begin
                    w_next     = IDLE;
                    w_done_set = 1'b1;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Strobe only in STROBE for legal writes; reset suppresses it at once.
    always_comb begin
        FrameStrobe = '0;
        if (r_state == STROBE && w_legal && !reset) begin
            FrameStrobe = OneHot << r_frame;
        end
    end

    // Datapath: header fields, data word, frame index, counters and flags.
    always_ff @(posedge CLK) begin
        if (reset) begin
            FrameData   <= '0;
            ColSel      <= 8'd0;
            r_frame     <= 6'd0;
            r_remaining <= 8'd0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= w_done_set;
            if (w_hdr_acc) begin
                ColSel      <= s_data[15:8];
                r_frame     <= {1'b0, s_data[31:27]};
                r_remaining <= s_data[7:0];
                err         <= 1'b0;
            end
            if (w_data_acc) begin
                FrameData   <= s_data;
                r_remaining <= r_remaining - 8'd1;
            end
            if (w_err_set) begin
                err <= 1'b1;
            end
            if (r_state == HOLD && r_frame != FrameSat) begin
                r_frame <= r_frame + 6'd1;
            end
        end
    end

    // Errors arise only in SETUP, so they never collide with a header clear.
    always_ff @(posedge CLK) begin
        if (!reset) begin
            assert (!(w_hdr_acc && w_err_set));
        end
    end

endmodule

// File: doc/frame_write_sequencer.md
FRAME_WRITE_SEQUENCER -- requirements
Module: frame_write_sequencer

Interface
REQ-001 Parameter FrameBitsPerRow, default 32: width of the configuration data word and of FrameData.
REQ-002 Parameter MaxFramesPerCol, default 20: width of FrameStrobe and the number of valid frame indices (0..MaxFramesPerCol-1).
REQ-003 Parameter NumColumns, default 16: number of valid column indices (0..NumColumns-1). ColSel width = 8.
REQ-004 Port CLK, input, 1: the single clock; all state changes on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port s_valid, input, 1: upstream word valid.
REQ-007 Port s_data, input, FrameBitsPerRow: upstream word, either header or frame data.
REQ-008 Port s_ready, output, 1: sequencer accepts s_data this cycle; transfer = s_valid & s_ready.
REQ-009 Port FrameData, output, FrameBitsPerRow: configuration data to the selected column's frame chain.
REQ-010 Port FrameStrobe, output, MaxFramesPerCol: one-hot frame write strobe.
REQ-011 Port ColSel, output, 8: column index qualifying FrameStrobe.
REQ-012 Port busy, output, 1: high in every state except IDLE.
REQ-013 Port done, output, 1: single-cycle pulse when a burst completes.
REQ-014 Port err, output, 1: sticky error flag.

Function
REQ-015 States: IDLE, WAIT_DATA, SETUP, STROBE, HOLD. s_ready is 1 only in IDLE and WAIT_DATA and depends on state only.
REQ-016 Header (accepted in IDLE): bits [31:27] = start frame F, [15:8] = column C, [7:0] = count N. Bits [26:16] are ignored.
REQ-017 On header accept: ColSel<=C, frame index<=F, remaining<=N. Next state is WAIT_DATA if N!=0. If N==0, next state is IDLE and done pulses on the following cycle.
REQ-018 Data accept in WAIT_DATA: FrameData<=s_data, remaining decrements, next state SETUP.
REQ-019 SETUP lasts 1 cycle: FrameData stable, FrameStrobe=0.
REQ-020 STROBE lasts 1 cycle: FrameStrobe = one-hot(frame index) when the write is legal; otherwise FrameStrobe=0.
REQ-021 HOLD lasts 1 cycle: FrameData held, FrameStrobe=0. Frame index increments by 1.
REQ-022 After HOLD: go to WAIT_DATA if remaining!=0. Otherwise go to IDLE and assert done for 1 cycle, concurrent with the first IDLE cycle.
REQ-023 Latency: data accepted at edge t gives SETUP during cycle t+1, strobe during t+2, HOLD during t+3, s_ready high again at t+4. Maximum throughput is 1 frame per 4 cycles.
REQ-024 A write is illegal when frame index >= MaxFramesPerCol or C >= NumColumns.
  - An illegal write still consumes its data word and steps through SETUP/STROBE/HOLD with no strobe.
  - err is set in the STROBE cycle.
REQ-025 Frame index is a 6-bit counter and does not wrap within a burst. Once it exceeds MaxFramesPerCol-1, every remaining frame of the burst is illegal.
REQ-026 err is sticky and is cleared only by reset or by the next header accept. If a header accept and an error occur in the same cycle, the header clear wins; this cannot occur by construction and shall be asserted.
REQ-027 FrameData changes only on data accept or reset, never during SETUP/STROBE/HOLD. ColSel changes only on header accept or reset.
REQ-028 s_valid while s_ready=0 has no effect. s_data is not sampled and upstream holds it.
REQ-029 FrameStrobe shall never have more than one bit set, and shall be nonzero only in STROBE.

Reset
REQ-030 When reset is high at a clock edge: state<=IDLE, FrameData<=0, FrameStrobe<=0, ColSel<=0, frame index<=0, remaining<=0, busy<=0, done<=0, err<=0.
REQ-031 Reset mid-burst aborts immediately.
  - No strobe is issued in the reset cycle or after it.
  - Words not yet accepted remain upstream.
  - The first cycle after reset deasserts is IDLE with s_ready=1.

Verification
REQ-032 Header F=3,C=2,N=2, then data 0xA5A5A5A5 and 0x5A5A5A5A with s_valid held high -> FrameStrobe=0x00008 then 0x00010, ColSel=2, one strobe per word, done one cycle after the second HOLD, err=0.
REQ-033 Header F=19,C=0,N=2 -> first frame strobes bit 19. Second frame: no strobe, err=1 set in its STROBE cycle, done still pulses.
REQ-034 Header with N=0 -> no strobe, done pulses, busy low throughout, s_ready stays 1.
REQ-035 Header C=16 with NumColumns=16 -> all frames are non-strobing with err=1. The next legal header clears err.
REQ-036 Reset asserted during the STROBE cycle of frame 1 of N=4 -> FrameStrobe=0 from the next edge, all outputs at their reset values, the following header is accepted normally.
REQ-037 Random s_valid gaps with a scoreboard -> every accepted data word produces exactly one legal strobe with matching FrameData, the one-hot invariant holds, and the 4-cycle spacing is never violated.
